// File: rtl/demux1_2_stream_if.sv
// Valid/ready stream bundle: data, last, valid, ready.
// master drives data/last/valid and samples ready; slave is the reverse.
interface demux1_2_stream_if #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         last;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output last,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  last,
        input  valid,
        output ready
    );
endinterface

// File: rtl/demux1_2_stream.sv
// 1:2 packet demux: routes a valid/ready stream to out0 or out1,
// with destination chosen at a packet's first beat and locked until its last beat.
// Ports: clk, rst_n (async active-low), sel, in_s (slave stream),
// out0/out1 (registered master streams), busy, cnt0/cnt1 (packet counters).
module demux1_2_stream #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sel,
    demux1_2_stream_if.slave  in_s,
    demux1_2_stream_if.master out0,
    demux1_2_stream_if.master out1,
    output logic           busy,
    output logic [CW-1:0]  cnt0,
    output logic [CW-1:0]  cnt1
);
    typedef enum logic {IDLE, LOCK} state_e;

    state_e        state_q, state_d;
    logic          lock_sel_q, lock_sel_d;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic [W-1:0]  d0_q, d0_d, d1_q, d1_d;
    logic          l0_q, l0_d, l1_q, l1_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic target;
    logic in_ready;
    logic acc;

    // In IDLE the live sel decides; in LOCK the latched choice holds.
    always_comb begin
        target   = (state_q == LOCK) ? lock_sel_q : sel;
        in_ready = target ? (!v1_q || out1.ready) : (!v0_q || out0.ready);
        acc      = in_s.valid && in_ready;
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        l0_d       = l0_q;
        l1_d       = l1_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;

        if (acc) begin
            unique case (state_q)
                IDLE: begin
                    if (!in_s.last) begin
                        state_d    = LOCK;
                        lock_sel_d = sel;
                    end
                end
                LOCK: begin
                    if (in_s.last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Load wins over drain so a beat can refill a draining register.
        if (acc && !target) begin
            v0_d = 1'b1;
            d0_d = in_s.data;
            l0_d = in_s.last;
            if (in_s.last) cnt0_d = cnt0_q + 1'b1;
        end else if (v0_q && out0.ready) begin
            v0_d = 1'b0;
        end

        if (acc && target) begin
            v1_d = 1'b1;
            d1_d = in_s.data;
            l1_d = in_s.last;
            if (in_s.last) cnt1_d = cnt1_q + 1'b1;
        end else if (v1_q && out1.ready) begin
            v1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= 1'b0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            d0_q       <= '0;
            d1_q       <= '0;
            l0_q       <= 1'b0;
            l1_q       <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            l0_q       <= l0_d;
            l1_q       <= l1_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign in_s.ready = in_ready;
    assign out0.data  = d0_q;
    assign out0.last  = l0_q;
    assign out0.valid = v0_q;
    assign out1.data  = d1_q;
    assign out1.last  = l1_q;
    assign out1.valid = v1_q;
    assign busy       = (state_q == LOCK);
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;
endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed self-checking bench for demux1_2_stream.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_demux1_2_stream;
    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          sel;
    logic          busy;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int checks   = 0;
    int failures = 0;

    demux1_2_stream_if #(.W(W)) in_if ();
    demux1_2_stream_if #(.W(W)) o0_if ();
    demux1_2_stream_if #(.W(W)) o1_if ();

    demux1_2_stream #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .in_s  (in_if),
        .out0  (o0_if),
        .out1  (o1_if),
        .busy  (busy),
        .cnt0  (cnt0),
        .cnt1  (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic s, input logic [W-1:0] d,
                        input logic l);
        sel         = s;
        in_if.data  = d;
        in_if.last  = l;
        in_if.valid = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        sel         = 1'b0;
        in_if.data  = '0;
        in_if.last  = 1'b0;
        in_if.valid = 1'b0;
        o0_if.ready = 1'b1;
        o1_if.ready = 1'b1;
        #1 rst_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_v0", o0_if.valid, 0);
        chk("rst_v1", o1_if.valid, 0);
        chk("rst_d0", o0_if.data, 0);
        chk("rst_l1", o1_if.last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        rst_n = 1'b1;
        step();

        // 1: three-beat packet to port 0
        beat(0, 16'hA001, 0);
        chk("t1_rdy", in_if.ready, 1);
        step();
        chk("t1_a1_v", o0_if.valid, 1);
        chk("t1_a1_d", o0_if.data, 16'hA001);
        chk("t1_busy1", busy, 1);
        beat(0, 16'hA002, 0);
        step();
        chk("t1_a2_d", o0_if.data, 16'hA002);
        chk("t1_busy2", busy, 1);
        beat(0, 16'hA003, 1);
        step();
        chk("t1_a3_d", o0_if.data, 16'hA003);
        chk("t1_a3_l", o0_if.last, 1);
        chk("t1_busy3", busy, 0);
        chk("t1_cnt0", cnt0, 1);
        chk("t1_cnt1", cnt1, 0);
        chk("t1_v1", o1_if.valid, 0);
        in_if.valid = 1'b0;
        step();
        chk("t1_drain", o0_if.valid, 0);

        // 2: sel toggles mid-packet, all beats stay on port 1
        beat(1, 16'hB001, 0);
        step();
        chk("t2_b1_d", o1_if.data, 16'hB001);
        beat(0, 16'hB002, 0);
        step();
        chk("t2_b2_d", o1_if.data, 16'hB002);
        chk("t2_b2_v0", o0_if.valid, 0);
        beat(0, 16'hB003, 0);
        step();
        chk("t2_b3_d", o1_if.data, 16'hB003);
        chk("t2_b3_v0", o0_if.valid, 0);
        beat(0, 16'hB004, 1);
        step();
        chk("t2_b4_d", o1_if.data, 16'hB004);
        chk("t2_b4_l", o1_if.last, 1);
        chk("t2_b4_v0", o0_if.valid, 0);
        chk("t2_cnt1", cnt1, 1);
        chk("t2_cnt0", cnt0, 1);
        in_if.valid = 1'b0;
        step();

        // 3: port 1 backpressure holds the locked packet
        o1_if.ready = 1'b0;
        beat(1, 16'hC001, 0);
        step();
        chk("t3_c1_v", o1_if.valid, 1);
        chk("t3_c1_d", o1_if.data, 16'hC001);
        beat(0, 16'hC002, 0);
        chk("t3_stall_rdy", in_if.ready, 0);
        step();
        chk("t3_hold_d", o1_if.data, 16'hC001);
        chk("t3_hold_v0", o0_if.valid, 0);
        step();
        chk("t3_hold2_d", o1_if.data, 16'hC001);
        chk("t3_hold2_rdy", in_if.ready, 0);
        o1_if.ready = 1'b1;
        #1;
        chk("t3_rel_rdy", in_if.ready, 1);
        step();
        chk("t3_c2_d", o1_if.data, 16'hC002);
        chk("t3_c2_v0", o0_if.valid, 0);
        beat(0, 16'hC003, 1);
        step();
        chk("t3_c3_d", o1_if.data, 16'hC003);
        chk("t3_cnt1", cnt1, 2);
        in_if.valid = 1'b0;
        step();
        chk("t3_drain", o1_if.valid, 0);

        // 4: alternating single-beat packets at full rate
        beat(0, 16'hD000, 1);
        chk("t4_rdy0", in_if.ready, 1);
        step();
        chk("t4_d0", o0_if.data, 16'hD000);
        beat(1, 16'hD001, 1);
        chk("t4_rdy1", in_if.ready, 1);
        step();
        chk("t4_d1", o1_if.data, 16'hD001);
        chk("t4_d1_v0", o0_if.valid, 0);
        beat(0, 16'hD002, 1);
        chk("t4_rdy2", in_if.ready, 1);
        step();
        chk("t4_d2", o0_if.data, 16'hD002);
        beat(1, 16'hD003, 1);
        chk("t4_rdy3", in_if.ready, 1);
        step();
        chk("t4_d3", o1_if.data, 16'hD003);
        chk("t4_cnt0", cnt0, 3);
        chk("t4_cnt1", cnt1, 4);
        chk("t4_busy", busy, 0);
        in_if.valid = 1'b0;
        step();

        // 5: async reset mid-packet
        beat(0, 16'hE001, 0);
        step();
        beat(0, 16'hE002, 0);
        step();
        chk("t5_pre_d", o0_if.data, 16'hE002);
        chk("t5_pre_busy", busy, 1);
        in_if.valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_v0", o0_if.valid, 0);
        chk("t5_v1", o1_if.valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cnt0", cnt0, 0);
        chk("t5_cnt1", cnt1, 0);
        #1 rst_n = 1'b1;
        beat(1, 16'hF001, 1);
        step();
        chk("t5_f1_v1", o1_if.valid, 1);
        chk("t5_f1_d", o1_if.data, 16'hF001);
        chk("t5_f1_v0", o0_if.valid, 0);
        chk("t5_cnt1b", cnt1, 1);
        chk("t5_busy2", busy, 0);

        // 6: counter wrap on port 0
        beat(0, 16'h0600, 1);
        for (int i = 0; i < 255; i++) begin
            in_if.data = W'(i);
            step();
        end
        chk("t6_cnt0_255", cnt0, 255);
        step();
        chk("t6_cnt0_wrap", cnt0, 0);
        chk("t6_cnt1", cnt1, 1);
        in_if.valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux1_2_stream.md
Name: demux1_2_stream

Overview:
- Routes one valid/ready data stream to one of two downstream consumers.
- Each packet's destination is chosen by `sel` at the packet's first beat and held until its last beat.
- Used in Wild Cube wherever a shared producer (e.g. tile/pixel or event stream) fans out to two consumers.
- Each output has a one-entry registered stage, so the path is fully registered.
- Per-port packet counters are provided for debug display.

Parameters:
- W, 16, data width in bits.
- CW, 8, width of each per-port packet counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  1  destination for a new packet (0 → port 0, 1 → port 1); sampled only on a packet's first beat.
- in_data  in  W  input payload.
- in_last  in  1  marks final beat of a packet.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- out0_data  out  W  port 0 payload.
- out0_last  out  1  port 0 last flag.
- out0_valid  out  1  port 0 beat valid.
- out0_ready  in  1  port 0 consumer accepts.
- out1_data  out  W  port 1 payload.
- out1_last  out  1  port 1 last flag.
- out1_valid  out  1  port 1 beat valid.
- out1_ready  in  1  port 1 consumer accepts.
- busy  out  1  a packet is in progress (destination locked).
- cnt0  out  CW  packets fully accepted toward port 0.
- cnt1  out  CW  packets fully accepted toward port 1.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; lock_sel=0; out0_valid=out1_valid=0; out*_data=0; out*_last=0; cnt0=cnt1=0; busy=0.
- FSM, 2 states:
  - IDLE: target = sel (combinational).
  - LOCK: target = lock_sel.
  - IDLE → LOCK on an accepted beat with in_last=0; latch lock_sel=sel.
  - LOCK → IDLE on an accepted beat with in_last=1.
  - An accepted beat with in_last=1 while in IDLE is a single-beat packet; FSM stays in IDLE.
  - busy = (state==LOCK).
- Acceptance:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !outT_valid || outT_ready, where T = target.
  - in_ready depends only on the target port; the non-target port never stalls input.
  - in_ready may depend combinationally on outT_ready and on sel (in IDLE).
- Output stage per port p:
  - On an accepted beat with target p: outp_data/outp_last <= in_data/in_last; outp_valid <= 1. Latency is exactly 1 cycle.
  - Else if outp_valid && outp_ready: outp_valid <= 0. Data and last hold their values.
  - Accepting a new beat in the same cycle the register drains is a simultaneous load, with no bubble. Throughput is 1 beat/clk when the consumer is always ready.
  - outp_valid, once high, stays high with data stable until outp_ready (AXI-style rule).
- sel changes:
  - In LOCK, sel is ignored; mid-packet toggles never misroute beats.
  - In IDLE with in_valid high and in_ready low, sel may change; the beat goes to whatever sel is on the accepting cycle.
- Counters:
  - cnt_p increments by 1 on each accepted beat with in_last=1 and target p.
  - Counters wrap modulo 2^CW; 255+1 → 0 for CW=8.
- Both ports may hold valid beats at once, from the tail of a port-0 packet plus the head of a new port-1 packet. Each drains independently.
- Reset mid-packet: all in-flight beats are discarded, valids drop immediately (async), FSM returns to IDLE. The next beat is treated as a first beat.
- No combinational path from in_data to out*_data.

Test Plan:
1. Reset, then sel=0, 3-beat packet (A1,A2,A3 last), out0_ready=1 → out0 shows A1..A3 at cycles 1..3 after acceptance; out1_valid stays 0; cnt0=1, cnt1=0, busy high during A1–A2 acceptance.
2. sel=1 for beat 1, sel toggled to 0 on beats 2–4 of a 4-beat packet → all 4 beats on out1, none on out0; cnt1=1.
3. out1_ready=0 with a packet to port 1 → one beat held on out1 and stable; in_ready=0; a concurrent IDLE sel=0 request is not accepted while the locked port-1 packet is stalled. Release ready → beats resume at 1/clk with no loss or duplication.
4. Back-to-back single-beat packets alternating sel 0,1,0,1 with both readys=1 → in_ready constantly 1; each port gets 2 beats; cnt0=cnt1=2.
5. Assert rst_n=0 mid-packet (after beat 2 of 5) → out0_valid/out1_valid drop asynchronously, cnt=0, busy=0. After release, a new sel=1 packet routes to port 1.
6. Send 256 single-beat packets to port 0 (CW=8) → cnt0 wraps to 0; cnt1 remains 0.
